ro_response_gen: RTL and testbench

Generates the raw PUF response from ring-oscillator pairs. It steps a pair-select index through all `N` oscillator pairs and counts rising edges of the selected oscillators A and B over a fixed window. Each comparison becomes one response bit. The finished `N`-bit vector and a one-cycle `ready` pulse feed the error-correction stage directly: `response` goes to its response input, and `ready` drives its `start`.

---
 rtl/puf_pkg.sv | 32 +++
 rtl/ro_edge_counter.sv | 59 +++++
 rtl/ro_response_gen.sv | 208 ++++++++++++++++++++
 tb/tb_ro_response_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_pkg
//  Description : Shared definitions for the ring-oscillator PUF datapath:
//                response width, edge-counter width, response-generator
//                state encoding and a small elaboration-time helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package puf_pkg;

    // Response width, shared with the error-correction stage.
    localparam int PUF_N    = 264;
    // Default width of each ring-oscillator edge counter.
    localparam int RO_CNT_W = 16;

    // Response-generator states. The ST_ prefix keeps the names clear of
    // the SETTLE / WINDOW timing parameters of the generator.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } puf_state_e;

    // Larger of two integers, used to size shared phase counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : puf_pkg
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_edge_counter
//  Description : Synchronises one asynchronous ring-oscillator output with a
//                2-FF synchroniser plus one extra stage for edge detection,
//                and counts rising edges into a saturating counter.
//  Ports       : clk    - system clock
//                rst    - synchronous active-high reset
//                ro_in  - asynchronous oscillator output
//                clr    - synchronous counter clear (priority over en)
//                en     - count enable
//                count  - current edge count (saturates at all ones)
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W = RO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // r_sync[0..1] form the synchroniser, r_sync[2] is the delayed copy
    // used to find the rising edge. The chain runs regardless of en/clr.
    logic [2:0]       r_sync;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;
    logic             w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], ro_in};
        end
    end

    assign w_rise = r_sync[1] & ~r_sync[2];
    assign w_sat  = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && w_rise && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : ro_edge_counter
`default_nettype wire

// File: rtl/ro_response_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ro_response_gen
//  Description : Steps through N ring-oscillator pairs, counts rising edges
//                of the selected oscillators A and B over a fixed window and
//                records (count A > count B) as one response bit per pair.
//                A one-cycle ready pulse marks the completed response.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                start    - begin a response generation (IDLE only)
//                ro_a     - selected oscillator A (asynchronous)
//                ro_b     - selected oscillator B (asynchronous)
//                pair_sel - pair index for the external oscillator mux
//                ro_en    - oscillator enable
//                busy     - high whenever the generator is not idle
//                response - N-bit response, bit i belongs to pair i
//                ready    - one-cycle pulse, response complete
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_response_gen
    import puf_pkg::*;
#(
    parameter int N      = PUF_N,
    parameter int CNT_W  = RO_CNT_W,
    parameter int SETTLE = 16,
    parameter int WINDOW = 1024,
    parameter int SEL_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [SEL_W-1:0] pair_sel,
    output logic             ro_en,
    output logic             busy,
    output logic [N-1:0]     response,
    output logic             ready
);

    // One phase counter serves both the settle and the window interval.
    localparam int                c_PH_MAX      = max_int(SETTLE, WINDOW);
    localparam int                c_PH_W        = $clog2(c_PH_MAX + 1);
    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE - 1);
    localparam logic [c_PH_W-1:0] c_WINDOW_LAST = c_PH_W'(WINDOW - 1);
    localparam logic [SEL_W-1:0]  c_LAST_PAIR   = SEL_W'(N - 1);

    puf_state_e        r_state;
    puf_state_e        w_state_nxt;
    logic [c_PH_W-1:0] r_phase;
    logic [SEL_W-1:0]  r_pair_sel;
    logic [N-1:0]      r_response;

    logic              w_settle_done;
    logic              w_window_done;
    logic              w_last_pair;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_bit;
    logic              w_ro_en;
    logic              w_busy;
    logic              w_ready;
    logic [CNT_W-1:0]  w_cnt_a;
    logic [CNT_W-1:0]  w_cnt_b;

    assign w_settle_done = (r_phase == c_SETTLE_LAST);
    assign w_window_done = (r_phase == c_WINDOW_LAST);
    assign w_last_pair   = (r_pair_sel == c_LAST_PAIR);

    // Counters are held at zero while the oscillators settle, so anything
    // still in the synchronisers from the previous pair is discarded.
    assign w_cnt_clr     = (r_state == ST_SETTLE);
    assign w_cnt_en      = (r_state == ST_COUNT);
    assign w_bit         = (w_cnt_a > w_cnt_b);

    // ------------------------------------------------------------------
    // Edge counters
    // ------------------------------------------------------------------
    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_a),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_cnt_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_b),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_cnt_b)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ro_en     = 1'b0;
        w_busy      = 1'b1;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_ro_en = 1'b1;
                if (w_settle_done) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                w_ro_en = 1'b1;
                if (w_window_done) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_ro_en     = 1'b1;
                w_state_nxt = w_last_pair ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter, pair index and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_pair_sel <= '0;
            r_response <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    if (start) begin
                        r_pair_sel <= '0;
                        r_response <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_phase <= w_settle_done ? '0 : r_phase + c_PH_W'(1);
                end
                ST_COUNT: begin
                    r_phase <= w_window_done ? '0 : r_phase + c_PH_W'(1);
                end
                ST_COMPARE: begin
                    r_phase <= '0;
                    // Decoded write keeps the index within 0..N-1 even when
                    // N is not a power of two.
                    for (int i = 0; i < N; i++) begin
                        if (r_pair_sel == SEL_W'(i)) begin
                            r_response[i] <= w_bit;
                        end
                    end
                    if (!w_last_pair) begin
                        r_pair_sel <= r_pair_sel + SEL_W'(1);
                    end
                end
                ST_DONE: begin
                    r_phase    <= '0;
                    r_pair_sel <= '0;
                end
                default: begin
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign pair_sel = r_pair_sel;
    assign ro_en    = w_ro_en;
    assign busy     = w_busy;
    assign ready    = w_ready;
    assign response = r_response;

endmodule : ro_response_gen
`default_nettype wire

// File: tb/tb_ro_response_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_response_gen
//  Description : Directed self-checking bench for ro_response_gen with
//                N=4, SETTLE=4, WINDOW=32, CNT_W=8, plus a second instance
//                with CNT_W=3, N=2 for counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_response_gen;
    import puf_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ro_a;
    logic       ro_b;
    logic [1:0] pair_sel;
    logic       ro_en;
    logic       busy;
    logic [3:0] response;
    logic       ready;

    logic       start_sat;
    logic       sat_a;
    logic       sat_b;
    logic [0:0] sat_pair_sel;
    logic       sat_ro_en;
    logic       sat_busy;
    logic [1:0] sat_response;
    logic       sat_ready;

    int checks;
    int errors;
    int tbl;

    // Half periods (cycles) of A and B per pair; table 0 = normal stimulus,
    // table 1 = inverted stimulus for the back-to-back run.
    int half_a [0:1][0:3] = '{'{2, 4, 2, 2}, '{4, 2, 2, 3}};
    int half_b [0:1][0:3] = '{'{4, 2, 2, 3}, '{2, 4, 4, 2}};

    ro_response_gen #(
        .N      (4),
        .CNT_W  (8),
        .SETTLE (4),
        .WINDOW (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ro_a     (ro_a),
        .ro_b     (ro_b),
        .pair_sel (pair_sel),
        .ro_en    (ro_en),
        .busy     (busy),
        .response (response),
        .ready    (ready)
    );

    ro_response_gen #(
        .N      (2),
        .CNT_W  (3),
        .SETTLE (4),
        .WINDOW (32)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .start    (start_sat),
        .ro_a     (sat_a),
        .ro_b     (sat_b),
        .pair_sel (sat_pair_sel),
        .ro_en    (sat_ro_en),
        .busy     (sat_busy),
        .response (sat_response),
        .ready    (sat_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // External oscillator mux model for the main instance.
    initial begin
        int ca, cb, sel, last_sel, st_cnt;
        ca = 0; cb = 0; last_sel = 0; st_cnt = 0;
        ro_a = 1'b0; ro_b = 1'b0;
        forever begin
            @(negedge clk);
            sel = int'(pair_sel);
            if (tbl == 2) begin
                // Leak pattern: rising edges only in SETTLE and COMPARE.
                ro_b = 1'b0;
                if (dut.r_state == ST_SETTLE) st_cnt++;
                else st_cnt = 0;
                ro_a = (dut.r_state == ST_COMPARE) || (st_cnt == 2);
            end else begin
                if (sel != last_sel) begin
                    ca = 0; cb = 0; ro_a = 1'b0; ro_b = 1'b0;
                end
                ca++;
                if (ca >= half_a[tbl][sel]) begin ro_a = ~ro_a; ca = 0; end
                cb++;
                if (cb >= half_b[tbl][sel]) begin ro_b = ~ro_b; cb = 0; end
            end
            last_sel = sel;
        end
    end

    // Free-running oscillators for the saturation instance: periods 4 and 6.
    initial begin
        int sa, sb;
        sa = 0; sb = 0;
        sat_a = 1'b0; sat_b = 1'b0;
        forever begin
            @(negedge clk);
            sa++;
            if (sa >= 2) begin sat_a = ~sat_a; sa = 0; end
            sb++;
            if (sb >= 3) begin sat_b = ~sat_b; sb = 0; end
        end
    end

    // Pulses start in cycle 0 and observes cycles 1..max_cyc; optionally
    // re-pulses start in cycle extra_cyc.
    task automatic run_capture(input int max_cyc, input int extra_cyc,
                               output int rdy_cyc, output int rdy_cnt,
                               output int busy_err);
        rdy_cyc = -1; rdy_cnt = 0; busy_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == extra_cyc);
            if (ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = c;
            end
            if (rdy_cyc < 0 && !busy) busy_err++;
            if (rdy_cyc >= 0 && c > rdy_cyc && busy) busy_err++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pair_sel !== 2'd0) begin errors++; $display("FAIL reset_pair_sel: got %0d expected 0", pair_sel); end
        checks++; if (ro_en !== 1'b0) begin errors++; $display("FAIL reset_ro_en: got %b expected 0", ro_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (response !== 4'b0000) begin errors++; $display("FAIL reset_response: got %b expected 0000", response); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int rc, rn, be;
        tbl = 0;
        run_capture(160, -1, rc, rn, be);
        checks++; if (rc != 149) begin errors++; $display("FAIL basic_ready_cycle: got %0d expected 149", rc); end
        checks++; if (rn != 1) begin errors++; $display("FAIL basic_ready_count: got %0d expected 1", rn); end
        checks++; if (be != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles expected 0", be); end
        checks++; if (response !== 4'b1001) begin errors++; $display("FAIL basic_response: got %b expected 1001", response); end
        checks++; if (response[2] !== 1'b0) begin errors++; $display("FAIL basic_tie_bit: got %b expected 0", response[2]); end
        checks++; if (pair_sel !== 2'd0 || ro_en !== 1'b0) begin errors++; $display("FAIL basic_idle_outputs: got pair_sel=%0d ro_en=%b expected 0 0", pair_sel, ro_en); end
    endtask

    task automatic test_start_while_busy();
        int rc, rn, be;
        tbl = 0;
        run_capture(160, 55, rc, rn, be);
        checks++; if (rc != 149) begin errors++; $display("FAIL busy_start_ready_cycle: got %0d expected 149", rc); end
        checks++; if (rn != 1) begin errors++; $display("FAIL busy_start_ready_count: got %0d expected 1", rn); end
        checks++; if (be != 0) begin errors++; $display("FAIL busy_start_busy: got %0d bad cycles expected 0", be); end
        checks++; if (response !== 4'b1001) begin errors++; $display("FAIL busy_start_response: got %b expected 1001", response); end
    endtask

    task automatic test_reset_mid();
        int rc, rn, be, stray;
        tbl = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;          // cycle 90: pair 2 COUNT
        @(negedge clk);
        rst = 1'b0;
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        checks++; if (busy !== 1'b0 || ro_en !== 1'b0) begin errors++; $display("FAIL rstmid_busy_en: got busy=%b ro_en=%b expected 0 0", busy, ro_en); end
        checks++; if (pair_sel !== 2'd0) begin errors++; $display("FAIL rstmid_pair_sel: got %0d expected 0", pair_sel); end
        checks++; if (response !== 4'b0000) begin errors++; $display("FAIL rstmid_response: got %b expected 0000", response); end
        stray = 0;
        for (int c = 0; c < 80; c++) begin
            if (ready) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", stray); end
        run_capture(160, -1, rc, rn, be);
        checks++; if (rc != 149) begin errors++; $display("FAIL rstmid_rerun_cycle: got %0d expected 149", rc); end
        checks++; if (response !== 4'b1001) begin errors++; $display("FAIL rstmid_rerun_response: got %b expected 1001", response); end
    endtask

    task automatic test_back_to_back();
        int r1, r2, nr;
        r1 = -1; r2 = -1; nr = 0;
        tbl = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ready) begin
                nr++;
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (r1 >= 0 && c == r1 + 1) begin
                checks++; if (response !== 4'b1001) begin errors++; $display("FAIL b2b_hold: got %b expected 1001", response); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
                start = 1'b1;
                tbl   = 1;
            end
            if (r1 >= 0 && c == r1 + 2) begin
                checks++; if (response !== 4'b0000) begin errors++; $display("FAIL b2b_clear: got %b expected 0000", response); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
            end
        end
        checks++; if (r1 != 149) begin errors++; $display("FAIL b2b_first_ready: got %0d expected 149", r1); end
        checks++; if (r2 != 299) begin errors++; $display("FAIL b2b_second_ready: got %0d expected 299", r2); end
        checks++; if (nr != 2) begin errors++; $display("FAIL b2b_ready_count: got %0d expected 2", nr); end
        checks++; if (response !== 4'b0110) begin errors++; $display("FAIL b2b_response: got %b expected 0110", response); end
        tbl = 0;
    endtask

    task automatic test_leak();
        int ncmp, rc;
        ncmp = 0; rc = -1;
        tbl = 2;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dut.r_state == ST_COMPARE) begin
                ncmp++;
                checks++;
                if (dut.w_cnt_a !== 8'd0 || dut.w_cnt_b !== 8'd0) begin
                    errors++;
                    $display("FAIL leak_counts: got a=%0d b=%0d expected 0 0", dut.w_cnt_a, dut.w_cnt_b);
                end
            end
            if (ready && rc < 0) rc = c;
        end
        checks++; if (ncmp != 4) begin errors++; $display("FAIL leak_compare_cycles: got %0d expected 4", ncmp); end
        checks++; if (rc != 149) begin errors++; $display("FAIL leak_ready_cycle: got %0d expected 149", rc); end
        checks++; if (response !== 4'b0000) begin errors++; $display("FAIL leak_response: got %b expected 0000", response); end
        tbl = 0;
    endtask

    task automatic test_saturation();
        int ncmp, rc;
        ncmp = 0; rc = -1;
        @(negedge clk);
        start_sat = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_sat = 1'b0;
            if (dut_sat.r_state == ST_COMPARE) begin
                ncmp++;
                checks++;
                if (dut_sat.w_cnt_a !== 3'd7) begin errors++; $display("FAIL sat_count_a: got %0d expected 7", dut_sat.w_cnt_a); end
                checks++;
                if (dut_sat.w_cnt_b < 3'd5 || dut_sat.w_cnt_b > 3'd6) begin errors++; $display("FAIL sat_count_b: got %0d expected 5..6", dut_sat.w_cnt_b); end
            end
            if (sat_ready && rc < 0) rc = c;
        end
        checks++; if (ncmp != 2) begin errors++; $display("FAIL sat_compare_cycles: got %0d expected 2", ncmp); end
        checks++; if (rc != 75) begin errors++; $display("FAIL sat_ready_cycle: got %0d expected 75", rc); end
        checks++; if (sat_response !== 2'b11) begin errors++; $display("FAIL sat_response: got %b expected 11", sat_response); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        tbl       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        start_sat = 1'b0;
        test_reset();
        test_basic();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_leak();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ro_response_gen
`default_nettype wire
